// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types for the program-counter sequencer.
//   state_e  : sequencer FSM states (IDLE, FETCH, HALT, ERROR)
//   pc_sel_e : next-PC source select (increment, target, return stack, hold)
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2,
        ERROR = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_INC  = 2'd0,
        SEL_TGT  = 2'd1,
        SEL_RAS  = 2'd2,
        SEL_HOLD = 2'd3
    } pc_sel_e;

endpackage : pc_seq_pkg

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Return-address stack: LIFO of RAS_DEPTH entries with a pointer 0..RAS_DEPTH.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears pointer)
//   push_i        : write push_data_i on top (ignored when full)
//   pop_i         : discard top entry (ignored when empty)
//   push_data_i   : return address to push
//   top_o         : current top entry (meaningless when empty_o)
//   full_o        : RAS_DEPTH entries held
//   empty_o       : no entries held
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int PC_WIDTH  = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [PC_WIDTH-1:0] push_data_i,
    output logic [PC_WIDTH-1:0] top_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]    sp_q;
    logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    top_idx;

    assign full_o  = (sp_q == PTR_W'(RAS_DEPTH));
    assign empty_o = (sp_q == '0);

    // RAS_DEPTH is a power of two, so the low pointer bits address the array
    // directly and top = sp-1 wraps correctly when the stack is full.
    assign wr_idx  = sp_q[IDX_W-1:0];
    assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign top_o   = mem_q[top_idx];

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - PTR_W'(1);
        end
    end

    // NOTE: the entry storage has no reset; the pointer alone defines which
    // entries are valid, and leaving the array unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule : ras_stack

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the PC, issues instruction fetches and selects the next PC from
// increment, jump/call target, return-address stack, or hold.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   jump, isjump    : conditional-taken / unconditional jump
//   iscall, isret   : call / return decoded
//   ishalt          : halt decoded
//   target          : jump/call destination
//   resume          : leave HALT
//   imem_ready      : instruction memory has data for pc
//   pc              : current fetch address
//   imem_req        : fetch request (high only in FETCH)
//   instr_valid     : instruction at pc executes this cycle
//   halted          : in HALT or ERROR
//   ras_overflow    : sticky, call on full stack
//   ras_underflow   : sticky, return on empty stack
// -----------------------------------------------------------------------------
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int PC_WIDTH  = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump,
    input  logic                isjump,
    input  logic                iscall,
    input  logic                isret,
    input  logic                ishalt,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                resume,
    input  logic                imem_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic                imem_req,
    output logic                instr_valid,
    output logic                halted,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] ras_top;
    logic                imem_req_q;
    logic                halted_q;
    logic                ovf_q;
    logic                unf_q;

    pc_sel_e             sel;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_full;
    logic                ras_empty;
    logic                exec;
    logic                go_halt;
    logic                err_ovf;
    logic                err_unf;

    // imem_req_q is high exactly while in FETCH, so it doubles as the state gate.
    assign exec   = imem_req_q & imem_ready;
    assign pc_inc = pc_q + PC_WIDTH'(1);

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    // Decode priority: halt > ret > call > jump > sequential.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        sel      = SEL_HOLD;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        go_halt  = 1'b0;
        err_ovf  = 1'b0;
        err_unf  = 1'b0;
        if (exec) begin
            if (ishalt) begin
                sel     = SEL_INC;
                go_halt = 1'b1;
            end else if (isret) begin
                if (ras_empty) begin
                    err_unf = 1'b1;
                end else begin
                    sel     = SEL_RAS;
                    ras_pop = 1'b1;
                end
            end else if (iscall) begin
                if (ras_full) begin
                    err_ovf = 1'b1;
                end else begin
                    sel      = SEL_TGT;
                    ras_push = 1'b1;
                end
            end else if (jump || isjump) begin
                sel = SEL_TGT;
            end else begin
                sel = SEL_INC;
            end
        end
    end

    always_comb begin
        case (sel)
            SEL_INC:  pc_d = pc_inc;
            SEL_TGT:  pc_d = target;
            SEL_RAS:  pc_d = ras_top;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (go_halt) begin
                        state_q    <= HALT;
                        imem_req_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (err_ovf || err_unf) begin
                        state_q    <= ERROR;
                        imem_req_q <= 1'b0;
                        halted_q   <= 1'b1;
                        ovf_q      <= ovf_q | err_ovf;
                        unf_q      <= unf_q | err_unf;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                default: begin
                    // ERROR is terminal until reset.
                    state_q <= ERROR;
                end
            endcase
        end
    end

    assign pc            = pc_q;
    assign imem_req      = imem_req_q;
    assign instr_valid   = exec;
    assign halted        = halted_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer (PC_WIDTH=10, RAS_DEPTH=4). A small
// reference model predicts the next pc; predictions are queued when stimulus
// is driven and popped/compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump, isjump, iscall, isret, ishalt, resume, imem_ready;
    logic [9:0] target;
    logic [9:0] pc;
    logic       imem_req, instr_valid, halted, ras_overflow, ras_underflow;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q [$];
    logic [9:0] m_pc;
    logic [9:0] m_ras [$];

    pc_sequencer #(.PC_WIDTH(10), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump          (jump),
        .isjump        (isjump),
        .iscall        (iscall),
        .isret         (isret),
        .ishalt        (ishalt),
        .target        (target),
        .resume        (resume),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .imem_req      (imem_req),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jump = 1'b0; isjump = 1'b0; iscall = 1'b0; isret = 1'b0;
        ishalt = 1'b0; resume = 1'b0; imem_ready = 1'b1; target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        m_pc = '0;
        m_ras.delete();
        exp_q.delete();
    endtask

    task automatic expect_pc(input string name, input logic [9:0] want);
        checks++;
        if (pc !== want) begin
            failures++;
            $display("FAIL %s: pc=%h expected=%h", name, pc, want);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b", name, got, want);
        end
    endtask

    // One FETCH cycle: drive decode inputs, queue the model's next pc,
    // clock, then pop and compare against the DUT.
    task automatic cycle(input logic j, input logic ij, input logic c, input logic r,
                         input logic h, input logic [9:0] tgt, input logic rdy);
        logic [9:0] e;
        jump = j; isjump = ij; iscall = c; isret = r; ishalt = h;
        target = tgt; imem_ready = rdy;
        #1;
        e = m_pc;
        if (rdy) begin
            if (h) e = m_pc + 10'd1;
            else if (r) begin
                if (m_ras.size() > 0) e = m_ras.pop_back();
            end else if (c) begin
                if (m_ras.size() < 4) begin
                    m_ras.push_back(m_pc + 10'd1);
                    e = tgt;
                end
            end else if (j || ij) e = tgt;
            else e = m_pc + 10'd1;
        end
        exp_q.push_back(e);
        checks++;
        if (instr_valid !== rdy) begin
            failures++;
            $display("FAIL instr_valid: got=%b expected=%b at pc=%h", instr_valid, rdy, pc);
        end
        tick();
        jump = 1'b0; isjump = 1'b0; iscall = 1'b0; isret = 1'b0; ishalt = 1'b0;
        imem_ready = 1'b1;
        m_pc = exp_q.pop_front();
        checks++;
        if (pc !== m_pc) begin
            failures++;
            $display("FAIL next_pc: pc=%h expected=%h", pc, m_pc);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #3;
        expect_pc("rst_pc", 10'h000);
        expect_bit("rst_imem_req", imem_req, 1'b0);
        expect_bit("rst_instr_valid", instr_valid, 1'b0);
        expect_bit("rst_halted", halted, 1'b0);
        expect_bit("rst_ovf", ras_overflow, 1'b0);
        expect_bit("rst_unf", ras_underflow, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_bit("idle_imem_req", imem_req, 1'b0);
        expect_bit("idle_instr_valid", instr_valid, 1'b0);
        tick();
        expect_bit("first_fetch_req", imem_req, 1'b1);
        expect_pc("first_fetch_pc", 10'h000);
        m_pc = '0;
        m_ras.delete();
        exp_q.delete();
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 0, 0, 0, 10'h000, 1);
            expect_pc("seq_pc", 10'(i));
            expect_bit("seq_req", imem_req, 1'b1);
        end
    endtask

    task automatic test_jump();
        cycle(0, 0, 0, 0, 0, 10'h000, 1);
        cycle(0, 0, 0, 0, 0, 10'h000, 1);
        expect_pc("reach_5", 10'h005);
        cycle(1, 0, 0, 0, 0, 10'h040, 1);
        expect_pc("jump_taken", 10'h040);
        cycle(0, 1, 0, 0, 0, 10'h005, 1);
        cycle(0, 0, 0, 0, 0, 10'h040, 1);
        expect_pc("jump_not_taken", 10'h006);
        cycle(0, 1, 0, 0, 0, 10'h005, 1);
        cycle(1, 0, 0, 0, 0, 10'h040, 0);
        expect_pc("stall1_hold", 10'h005);
        cycle(1, 0, 0, 0, 0, 10'h040, 0);
        expect_pc("stall2_hold", 10'h005);
        cycle(1, 0, 0, 0, 0, 10'h040, 1);
        expect_pc("jump_after_stall", 10'h040);
    endtask

    task automatic test_call_ret();
        cycle(0, 1, 0, 0, 0, 10'h010, 1);
        cycle(0, 0, 1, 0, 0, 10'h100, 1);
        expect_pc("call1", 10'h100);
        cycle(0, 0, 1, 0, 0, 10'h200, 1);
        expect_pc("call2", 10'h200);
        cycle(0, 0, 0, 1, 0, 10'h000, 1);
        expect_pc("ret1", 10'h101);
        cycle(0, 0, 0, 1, 0, 10'h000, 1);
        expect_pc("ret2", 10'h011);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 10'(32 * (i + 1)), 1);
        expect_bit("no_ovf_at_4", ras_overflow, 1'b0);
        iscall = 1'b1; target = 10'h300;
        tick();
        iscall = 1'b0;
        expect_bit("ovf_flag", ras_overflow, 1'b1);
        expect_bit("ovf_req_low", imem_req, 1'b0);
        expect_bit("ovf_halted", halted, 1'b1);
        expect_pc("ovf_pc_held", 10'h080);
        resume = 1'b1;
        tick();
        tick();
        resume = 1'b0;
        expect_bit("err_ignores_resume", imem_req, 1'b0);
        expect_bit("ovf_sticky", ras_overflow, 1'b1);
    endtask

    task automatic test_underflow();
        do_reset();
        isret = 1'b1;
        tick();
        isret = 1'b0;
        expect_bit("unf_flag", ras_underflow, 1'b1);
        expect_bit("unf_no_ovf", ras_overflow, 1'b0);
        expect_bit("unf_req_low", imem_req, 1'b0);
        expect_pc("unf_pc_held", 10'h000);
    endtask

    task automatic test_halt_wrap();
        do_reset();
        cycle(0, 0, 1, 0, 0, 10'h3FF, 1);
        cycle(0, 0, 1, 0, 1, 10'h123, 1);
        expect_pc("halt_wrap_pc", 10'h000);
        expect_bit("halted", halted, 1'b1);
        expect_bit("halt_req_low", imem_req, 1'b0);
        tick();
        expect_bit("halt_stays", halted, 1'b1);
        expect_pc("halt_pc_stable", 10'h000);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        expect_bit("resume_req", imem_req, 1'b1);
        expect_bit("resume_unhalted", halted, 1'b0);
        expect_pc("resume_pc", 10'h000);
        cycle(0, 0, 0, 1, 0, 10'h000, 1);
        expect_pc("stack_kept_ret", 10'h001);
        cycle(0, 1, 0, 0, 0, 10'h3FF, 1);
        cycle(0, 0, 1, 0, 0, 10'h050, 1);
        cycle(0, 0, 0, 1, 0, 10'h000, 1);
        expect_pc("call_push_wrap", 10'h000);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int          r;
            logic [9:0]  t;
            r = int'($urandom_range(0, 5));
            t = 10'($urandom_range(0, 1023));
            case (r)
                0: if (m_ras.size() < 4) cycle(0, 0, 1, 0, 0, t, 1);
                   else cycle(0, 0, 0, 0, 0, t, 1);
                1: if (m_ras.size() > 0) cycle(0, 0, 0, 1, 0, t, 1);
                   else cycle(1, 0, 0, 0, 0, t, 1);
                2: cycle(1, 0, 0, 0, 0, t, 1);
                3: cycle(0, 0, 1, 1, 1, t, 0);
                default: cycle(0, 0, 0, 0, 0, t, 1);
            endcase
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(0, 0, 1, 0, 0, 10'h100, 1);
        cycle(0, 0, 1, 0, 0, 10'h200, 1);
        imem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_pc("async_pc", 10'h000);
        expect_bit("async_req", imem_req, 1'b0);
        expect_bit("async_valid", instr_valid, 1'b0);
        expect_bit("async_halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;
        tick();
        isret = 1'b1;
        tick();
        isret = 1'b0;
        expect_bit("stack_cleared", ras_underflow, 1'b1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_halt_wrap();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_sequencer
